// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage and IF/ID pipeline register
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PC_IFWrite,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        if_busy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = redirect_target & ~32'h0000_0003;
    assign pc_plus4 = pc_q + 32'd4;

    // Fetch interface depends only on registered state, never on imem_ready.
    assign imem_req    = (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign if_busy     = (state_q != HOLD) && !imem_ready;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_instr    = id_instr_q;
    assign id_valid    = id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_buf_d    = hold_buf_q;
        pend_target_d = pend_target_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;

        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                        pc_d       = target;
                    end else if (PC_IFWrite) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = imem_rdata;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_plus4;
                        pc_d          = pc_plus4;
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_target_d = target;
                    id_valid_d    = 1'b0;
                    id_instr_d    = NOP_INSTR;
                    state_d       = DISCARD;
                end else if (PC_IFWrite) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    pc_d       = target;
                    state_d    = FETCH;
                end else if (PC_IFWrite) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = hold_buf_q;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_plus4;
                    pc_d          = pc_plus4;
                    state_d       = FETCH;
                end
            end

            DISCARD: begin
                // The outstanding word belongs to a squashed path; wait it out.
                if (redirect_valid) begin
                    pend_target_d = target;
                    id_valid_d    = 1'b0;
                    id_instr_d    = NOP_INSTR;
                end else if (PC_IFWrite) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? target : pend_target_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            hold_buf_q    <= 32'h0;
            pend_target_q <= 32'h0;
            id_pc_q       <= 32'h0;
            id_pc_plus4_q <= 32'd4;
            id_instr_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_buf_q    <= hold_buf_d;
            pend_target_q <= pend_target_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed-vector bench for if_id_stage
module tb_if_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        PC_IFWrite;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        if_busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Memory returns addr ^ 0xA5 so every word identifies its own address.
    assign imem_rdata = imem_addr ^ 32'h0000_00A5;

    if_id_stage dut (
        .clock          (clock),
        .reset          (reset),
        .PC_IFWrite     (PC_IFWrite),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .if_busy        (if_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        PC_IFWrite      = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ready      = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc_plus4, 32'h4);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h1);

        // 1: streaming fetch after reset
        reset = 1'b0;
        tick();
        check("s1_pc0", id_pc, 32'h0);
        check("s1_instr0", id_instr, 32'h0000_00A5);
        check("s1_valid0", {31'b0, id_valid}, 32'h1);
        check("s1_addr4", imem_addr, 32'h4);
        tick();
        check("s1_pc4", id_pc, 32'h4);
        check("s1_instr4", id_instr, 32'h0000_00A1);
        check("s1_addr8", imem_addr, 32'h8);

        // 2: load-use stall captures word into the hold buffer
        PC_IFWrite = 1'b0;
        tick();
        check("s2_req_hold", {31'b0, imem_req}, 32'h0);
        check("s2_idpc_held", id_pc, 32'h4);
        check("s2_busy_hold", {31'b0, if_busy}, 32'h0);
        tick();
        check("s2_req_hold2", {31'b0, imem_req}, 32'h0);
        check("s2_idpc_held2", id_pc, 32'h4);
        PC_IFWrite = 1'b1;
        tick();
        check("s2_idpc_8", id_pc, 32'h8);
        check("s2_instr_buf", id_instr, 32'h0000_00AD);
        check("s2_addr12", imem_addr, 32'hC);
        check("s2_req_back", {31'b0, imem_req}, 32'h1);

        // 3: redirect with ready, target low bits ignored
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        tick();
        check("s3_bubble", {31'b0, id_valid}, 32'h0);
        check("s3_nop", id_instr, 32'h0);
        check("s3_idpc_kept", id_pc, 32'h8);
        check("s3_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        tick();
        check("s3_idpc", id_pc, 32'h100);
        check("s3_instr", id_instr, 32'h0000_01A5);
        check("s3_addr104", imem_addr, 32'h104);

        // 4: redirects while a fetch is outstanding; newest target wins
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        check("s4_busy", {31'b0, if_busy}, 32'h1);
        tick();
        check("s4_addr_c1", imem_addr, 32'h104);
        check("s4_req_c1", {31'b0, imem_req}, 32'h1);
        check("s4_bubble_c1", {31'b0, id_valid}, 32'h0);
        redirect_target = 32'h300;
        tick();
        check("s4_addr_c2", imem_addr, 32'h104);
        redirect_valid = 1'b0;
        tick();
        check("s4_addr_c3", imem_addr, 32'h104);
        imem_ready = 1'b1;
        tick();
        check("s4_addr_new", imem_addr, 32'h300);
        check("s4_dropped", {31'b0, id_valid}, 32'h0);
        tick();
        check("s4_idpc", id_pc, 32'h300);
        check("s4_instr", id_instr, 32'h0000_03A5);

        // 5: PC wraps at the top of the address space
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        check("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        check("s5_idpc", id_pc, 32'hFFFF_FFFC);
        check("s5_pc4_wrap", id_pc_plus4, 32'h0);
        check("s5_instr", id_instr, 32'hFFFF_FF59);
        check("s5_addr_wrap", imem_addr, 32'h0);

        // 6a: reset out of HOLD drops the buffered word
        tick();
        PC_IFWrite = 1'b0;
        tick();
        check("s6_in_hold", {31'b0, imem_req}, 32'h0);
        reset = 1'b1;
        tick();
        check("s6a_addr", imem_addr, 32'h0);
        check("s6a_req", {31'b0, imem_req}, 32'h1);
        check("s6a_valid", {31'b0, id_valid}, 32'h0);
        reset      = 1'b0;
        PC_IFWrite = 1'b1;
        tick();
        check("s6a_instr", id_instr, 32'h0000_00A5);
        check("s6a_idpc", id_pc, 32'h0);

        // 6b: reset out of DISCARD forgets the pending target
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        check("s6b_in_discard", imem_addr, 32'h4);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        check("s6b_addr", imem_addr, 32'h0);
        check("s6b_valid", {31'b0, id_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("s6b_wait_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick();
        check("s6b_load_valid", {31'b0, id_valid}, 32'h1);
        check("s6b_load_pc", id_pc, 32'h0);
        check("s6b_next_addr", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
